mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Multi-cycle load/store unit between the core datapath and the word-addressed data memory (combinational read, synchronous write). It accepts one memory request at a time and performs word, halfword and byte loads with sign or zero extension. Word stores are written directly. Sub-word stores are handled by a read-modify-write sequence. It reports completion with a one-cycle `done` pulse and asserts `busy` so the core can stall.

## Interface

Parameters:
- `AW`, default 32: byte-address width of `addr` and `mem_a`.

Ports:
- `clk` in 1: single clock. Everything is sampled on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: request strobe. Sampled only in IDLE.
- `op` in 3: operation code. Encodings are in the shared package.
- `addr` in AW: byte address.
- `wdata` in 32: store data, right-aligned.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: misaligned access. Valid only with `done`.
- `rdata` out 32: load result. Held until the next `done`.
- `mem_a` out AW: word-aligned memory address.
- `mem_we` out 1: memory write enable.
- `mem_wd` out 32: memory write data.
- `mem_rd` in 32: memory read data (combinational from `mem_a`).

## Operation

**Op codes**
- LW=000, LH=001, LHU=010, LB=011, LBU=100, SW=101, SH=110, SB=111.

**Byte ordering and address**
- Little-endian: byte `k` = `addr[1:0]` occupies bits `[8k+7:8k]`.
- Halfword at `addr[1]` occupies bits `[16*addr[1]+15 : 16*addr[1]]`.
- `mem_a` = latched address with bits `[1:0]` forced to 0.

**Alignment rules**
- LW/SW need `addr[1:0]`=00.
- LH/LHU/SH need `addr[0]`=0.
- Byte ops are always aligned.

**FSM states:** IDLE, ACCESS, MERGE_WR, DONE.
- IDLE
  - If `req`=1, latch `op`, `addr`, `wdata` and go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS
  - Misaligned: no write; set `err_q`=1 and `rdata_q`=0; go to DONE.
  - Load: extract the selected lane from `mem_rd`, sign-extend (LH/LB) or zero-extend (LHU/LBU), store into `rdata_q`; go to DONE.
  - SW: `mem_we`=1, `mem_wd`=latched `wdata`; go to DONE.
  - SH/SB: latch the merged word = `mem_rd` with the target lane replaced by `wdata[15:0]` or `wdata[7:0]`; go to MERGE_WR.
- MERGE_WR: `mem_we`=1, `mem_wd`=merged word; go to DONE.
- DONE: `done`=1, `err`=`err_q`; go to IDLE.

**Request and data rules**
- `req` is ignored while `busy`. The core must hold or re-issue after `done`.
- Store operations leave `rdata` unchanged.
- `err` is cleared at the next accepted request.

**Reset**
- Reset forces IDLE.
- Clears `err_q` and `rdata_q` to 0.
- `mem_we` is gated by `!reset`, so a reset during ACCESS or MERGE_WR performs no write.

## Timing

**Reset values:** `busy`=0, `done`=0, `err`=0, `rdata`=0, `mem_we`=0, `mem_a`=0, `mem_wd`=0.

**Latency** (cycle 0 = the edge at which `req` is sampled in IDLE):
- Loads, SW, misaligned: `done` in cycle 2. Next request can be accepted at the end of cycle 3.
- SH/SB: `done` in cycle 3.

**Output timing**
- `mem_we` is a Moore output, high for exactly one cycle per store. The write takes effect at the edge ending that cycle.
- `mem_a` is stable from ACCESS through MERGE_WR.

**Back-to-back**
- `req` held high through DONE is accepted in the cycle after DONE.
- Throughput: one op per 3 cycles (4 for sub-word stores).

**Reset mid-operation:** no `done` pulse is emitted for the abandoned request.

## Structure

**Shared package `mau_pkg`:**
- Op-code localparams: `OP_LW` … `OP_SB`.
- State encoding localparams: `S_IDLE`, `S_ACCESS`, `S_MERGE_WR`, `S_DONE`.
- Function `is_store(op)`: `op` ≥ 101.

**Sub-module `byte_lane`:** combinational.
- Inputs: word, `addr[1:0]`, op, store data.
- Outputs: extracted, extended load value; merged store word; misalign flag.

**Top level:** FSM, latches and memory port drive.

## Test plan

- **LB sign extension:** memory word @0x10 = 0x8899AABB; LB addr 0x11 → `done` in cycle 2, `rdata`=0xFFFFFFAA, `err`=0.
- **LBU / LHU zero extension:** same word; LBU 0x13 → 0x00000088; LHU 0x12 → 0x00008899.
- **SB read-modify-write:** word @0x20 = 0x11223344; SB addr 0x21, `wdata`=0xFFFFFF55 → one `mem_we` pulse in cycle 2, memory = 0x11225544, `done` in cycle 3.
- **Misaligned accesses:**
  - LW 0x22 → `err`=1, `rdata`=0, no `mem_we`.
  - SH 0x23 → `err`=1, memory unchanged.
- **Busy and back-to-back:** `req` pulsed every cycle with SW 0x30=0xDEADBEEF, then LW 0x30 → second request accepted only after `done`; LW returns 0xDEADBEEF.
- **Reset mid-operation:** `reset` asserted during MERGE_WR of SB → no write (memory unchanged), no `done`, all outputs at reset values next cycle.

Source files
------------

// File: rtl/mau_pkg.sv
// rtl/mau_pkg.sv - shared op codes, state encoding and helpers for the load/store unit
package mau_pkg;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ACCESS   = 2'd1;
  localparam logic [1:0] S_MERGE_WR = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = S_IDLE,
    ST_ACCESS   = S_ACCESS,
    ST_MERGE_WR = S_MERGE_WR,
    ST_DONE     = S_DONE
  } state_t;

  function automatic logic is_store(input logic [2:0] op);
    return op >= OP_SW;
  endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane.sv
// rtl/mem_access_unit_byte_lane.sv - lane extract/extend, sub-word merge and alignment check
module byte_lane
  import mau_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  a,
  input  logic [2:0]  op,
  input  logic [31:0] sdata,
  output logic [31:0] load_val,
  output logic [31:0] merged,
  output logic        misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{a, 3'b000} +: 8];
    lane_h = word[{a[1], 4'b0000} +: 16];

    case (op)
      OP_LW, OP_SW:          misalign = (a != 2'b00);
      OP_LH, OP_LHU, OP_SH:  misalign = a[0];
      default:               misalign = 1'b0;
    endcase

    case (op)
      OP_LH:   load_val = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_val = {16'h0000, lane_h};
      OP_LB:   load_val = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_val = {24'h000000, lane_b};
      default: load_val = word;
    endcase

    merged = word;
    if (op == OP_SH) begin
      merged[{a[1], 4'b0000} +: 16] = sdata[15:0];
    end else if (op == OP_SB) begin
      merged[{a, 3'b000} +: 8] = sdata[7:0];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - multi-cycle load/store unit with read-modify-write sub-word stores
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [2:0]    op,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   rdata,
  output logic [AW-1:0] mem_a,
  output logic          mem_we,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   merged_q, merged_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   lane_load;
  logic [31:0]   lane_merged;
  logic          lane_misalign;

  byte_lane u_lane (
    .word     (mem_rd),
    .a        (addr_q[1:0]),
    .op       (op_q),
    .sdata    (wdata_q),
    .load_val (lane_load),
    .merged   (lane_merged),
    .misalign (lane_misalign)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          op_d    = op;
          addr_d  = addr;
          wdata_d = wdata;
          err_d   = 1'b0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (lane_misalign) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = ST_DONE;
        end else if (!is_store(op_q)) begin
          rdata_d = lane_load;
          state_d = ST_DONE;
        end else if (op_q == OP_SW) begin
          state_d = ST_DONE;
        end else begin
          merged_d = lane_merged;
          state_d  = ST_MERGE_WR;
        end
      end
      ST_MERGE_WR: state_d = ST_DONE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LW;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      merged_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign err    = done & err_q;
  assign rdata  = rdata_q;
  assign mem_a  = {addr_q[AW-1:2], 2'b00};
  // Reset gates the strobe directly so an abandoned store never reaches memory.
  assign mem_we = !reset && (((state_q == ST_ACCESS) && (op_q == OP_SW) && !lane_misalign)
                             || (state_q == ST_MERGE_WR));
  assign mem_wd = (state_q == ST_MERGE_WR) ? merged_q : wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed and random checks of mem_access_unit against a word-array model
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        clk = 1'b0;
  logic        reset, req;
  logic [2:0]  op;
  logic [31:0] addr, wdata;
  logic        busy, done, err, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;
  logic [31:0] exp_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.AW(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .op     (op),
    .addr   (addr),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .rdata  (rdata),
    .mem_a  (mem_a),
    .mem_we (mem_we),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd)
  );

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   {31'b0, busy},   32'h0);
    check({tag, "_done"},   {31'b0, done},   32'h0);
    check({tag, "_err"},    {31'b0, err},    32'h0);
    check({tag, "_rdata"},  rdata,           32'h0);
    check({tag, "_mem_we"}, {31'b0, mem_we}, 32'h0);
    check({tag, "_mem_a"},  mem_a,           32'h0);
    check({tag, "_mem_wd"}, mem_wd,          32'h0);
  endtask

  // Issue one request and compare latency, err, rdata, write count and memory with the model.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                       input string tag);
    logic [31:0] w, nw, er;
    logic [7:0]  bt;
    logic [15:0] hw;
    logic        mis, got;
    int          idx, sh, hs, lat, wes, cyc, we_cnt;
    idx = int'(a[7:2]);
    w   = ref_mem[idx];
    sh  = int'(a[1:0]) * 8;
    hs  = int'(a[1]) * 16;
    bt  = 8'(w >> sh);
    hw  = 16'(w >> hs);
    mis = ((o == OP_LW || o == OP_SW) && a[1:0] != 2'b00) ||
          ((o == OP_LH || o == OP_LHU || o == OP_SH) && a[0]);
    nw  = w;
    er  = exp_rdata;
    lat = 2;
    wes = 0;
    if (mis) er = 32'h0;
    else begin
      case (o)
        OP_LW:  er = w;
        OP_LH:  er = {{16{hw[15]}}, hw};
        OP_LHU: er = {16'h0, hw};
        OP_LB:  er = {{24{bt[7]}}, bt};
        OP_LBU: er = {24'h0, bt};
        OP_SW:  begin nw = wd; wes = 1; end
        OP_SH:  begin nw = (w & ~(32'hFFFF << hs)) | ((wd & 32'hFFFF) << hs); wes = 1; lat = 3; end
        default: begin nw = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh); wes = 1; lat = 3; end
      endcase
    end

    @(negedge clk);
    check({tag, "_idle_before"}, {31'b0, busy}, 32'h0);
    req = 1'b1; op = o; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0; op = 3'($urandom); addr = $urandom; wdata = $urandom;
    cyc = 0; got = 1'b0; we_cnt = 0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (mem_we) we_cnt++;
      if (done) begin
        got = 1'b1;
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_err"}, {31'b0, err}, {31'b0, mis});
        check({tag, "_rdata"}, rdata, er);
      end
    end
    if (!got) check({tag, "_done_timeout"}, 32'h0, 32'h1);
    check({tag, "_we_pulses"}, 32'(we_cnt), 32'(wes));
    check({tag, "_mem_word"}, mem[idx], nw);
    ref_mem[idx] = nw;
    exp_rdata = er;
  endtask

  initial begin
    int d1, d2, done_cnt;
    logic [31:0] v;
    reset = 1'b1; req = 1'b0; op = OP_LW; addr = 32'h0; wdata = 32'h0;
    pl_en = 1'b1; pl_idx = 6'd0; pl_val = 32'h0;
    exp_rdata = 32'h0;

    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      v = (i == 4) ? 32'h8899AABB : (i == 8) ? 32'h11223344 : $urandom;
      pl_idx = 6'(i); pl_val = v; ref_mem[i] = v;
    end
    @(negedge clk);
    pl_en = 1'b0;
    check_reset_outputs("reset");
    reset = 1'b0;

    do_op(OP_LB, 32'h11, 32'h0, "lb_sign");
    check("lb_sign_const", rdata, 32'hFFFFFFAA);
    do_op(OP_LBU, 32'h13, 32'h0, "lbu_zero");
    check("lbu_zero_const", rdata, 32'h00000088);
    do_op(OP_LHU, 32'h12, 32'h0, "lhu_zero");
    check("lhu_zero_const", rdata, 32'h00008899);
    do_op(OP_SB, 32'h21, 32'hFFFFFF55, "sb_rmw");
    check("sb_rmw_const", mem[8], 32'h11225544);
    do_op(OP_LW, 32'h22, 32'h0, "lw_misaligned");
    do_op(OP_SH, 32'h23, 32'hA5A5A5A5, "sh_misaligned");
    check("sh_misaligned_const", mem[8], 32'h11225544);

    // Request held high: the LW behind the SW must wait for the SW's done.
    @(negedge clk);
    req = 1'b1; op = OP_SW; addr = 32'h30; wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    op = OP_LW; wdata = 32'h0;
    d1 = -1; d2 = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 2) check("b2b_busy", {31'b0, busy}, 32'h1);
      if (done) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) begin
          d2 = c;
          req = 1'b0;
          check("b2b_lw_rdata", rdata, 32'hDEADBEEF);
        end
      end
    end
    req = 1'b0;
    check("b2b_first_done", 32'(d1), 32'd2);
    check("b2b_second_done", 32'(d2), 32'd5);
    check("b2b_mem", mem[12], 32'hDEADBEEF);
    ref_mem[12] = 32'hDEADBEEF;
    exp_rdata = 32'hDEADBEEF;

    // Reset while the merged word is being written.
    @(negedge clk);
    req = 1'b1; op = OP_SB; addr = 32'h25; wdata = 32'h000000C3;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    check("rst_mid_access_busy", {31'b0, busy}, 32'h1);
    @(negedge clk);
    check("rst_mid_merge_we", {31'b0, mem_we}, 32'h1);
    reset = 1'b1;
    #1;
    check("rst_mid_we_gated", {31'b0, mem_we}, 32'h0);
    @(negedge clk);
    check_reset_outputs("rst_mid");
    check("rst_mid_mem", mem[9], ref_mem[9]);
    reset = 1'b0;
    exp_rdata = 32'h0;
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("rst_mid_no_done", 32'(done_cnt), 32'h0);

    for (int n = 0; n < 40; n++) begin
      do_op(3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)), $urandom,
            $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
